minterm_sweep_checker: RTL
==========================

# minterm_sweep_checker

Self-running sweep stage wrapped around the 4-input minterm decoder. It drives the decoder's 4-bit select `S` through codes 0..15, waits a programmable settle time at each code, and samples the decoder output `O`. Each sample is compared against a 16-bit expected truth table; the block reports the mismatch count, the first failing code, and pass/done status. It sits directly upstream of the decoder (it produces `S`) and consumes the decoder's `O`, replacing the bench-only sweep with synthesizable on-board self-test.

## Interface

Parameters:
- `EXPECT_MASK`, default `16'hA888`: bit i is the required `O` for `S = i`. The default is minterms 3, 7, 11, 13 and 15.
- `SETTLE`, default `2`: number of clock cycles `S` is held before `O` is sampled. Legal range is 1..255.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a sweep; sampled in IDLE and DONE only.
- `S`  out  4  select code driven to the decoder.
- `O`  in  1  decoder output under test.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  high from sweep completion until the next accepted `start` or reset.
- `pass`  out  1  equals `done && err_count == 0`.
- `err_count`  out  5  number of mismatching codes, 0..16.
- `first_err`  out  4  lowest code that mismatched.
- `first_err_valid`  out  1  high once any mismatch has been recorded.

## Operation

- **States:** IDLE, DRIVE, SAMPLE, DONE.
- **Reset values** (asynchronous, immediate): state = IDLE, `S` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_count` = 0, `first_err` = 0, `first_err_valid` = 0. The settle counter is also cleared.
- **IDLE or DONE with `start` = 1:**
  - Clear `err_count`, `first_err` and `first_err_valid`.
  - Set `S` = 0, `busy` = 1, `done` = 0.
  - Load the settle counter with `SETTLE`, then go to DRIVE.
- **IDLE or DONE with `start` = 0:** hold all outputs.
- **DRIVE:** decrement the settle counter each cycle. Move to SAMPLE on the cycle the counter reaches 1. DRIVE therefore lasts exactly `SETTLE` cycles.
- **SAMPLE:** compare `O` with `EXPECT_MASK[S]`.
  - On mismatch, increment `err_count`.
  - If `first_err_valid` = 0, also load `first_err` = `S` and set `first_err_valid` = 1.
  - If `S` = 15: go to DONE, set `busy` = 0 and `done` = 1. `S` stays at 15.
  - Otherwise: increment `S`, reload the settle counter and return to DRIVE.
- **`start` during DRIVE or SAMPLE:** ignored. No restart and no effect on counters.
- **Arithmetic:** `err_count` is 5 bits wide, so the 16-error maximum cannot wrap. `S` never increments past 15 and never wraps to 0 during a sweep.
- **`O` synchronicity:** `O` is treated as synchronous to `clk`; the settle interval covers decoder propagation. No synchronizer is used.
- **`pass`:** registered. It is updated in the same cycle that `done` rises and cleared when a new `start` is accepted.

## Timing

- **Start:** `start` is sampled high at edge k. At edge k+1 the block is in DRIVE with `S` = 0 and `busy` = 1.
- **Per code:** each code occupies `SETTLE` + 1 cycles. Code i is sampled at the edge ending cycle k + (i+1)(`SETTLE`+1).
- **Completion:** `done` = 1 and `busy` = 0 after edge k + 16(`SETTLE`+1). With the default `SETTLE` = 2 this is 48 cycles after the `start` edge.
- **Status updates:** `err_count`, `first_err` and `first_err_valid` update on the SAMPLE edge of the failing code. They are visible the following cycle.
- **Simultaneous start and completion:** `start` held high continuously restarts a sweep on the first DONE cycle. `done` is then high for exactly one cycle.
- **Reset mid-sweep:** all outputs take their reset values immediately, with no partial result retained. A new `start` is required after reset.

## Test plan

- **Correct decoder:**
  - Stimulus: `O` modeled as (S==3|7|11|13|15), `SETTLE` = 2, pulse `start`.
  - Required: `done` 48 cycles later, `pass` = 1, `err_count` = 0, `first_err_valid` = 0.
- **`O` stuck at 0:**
  - Stimulus: tie `O` low, run one sweep.
  - Required: `err_count` = 5, `first_err` = 3, `first_err_valid` = 1, `pass` = 0.
- **`O` stuck at 1:**
  - Stimulus: tie `O` high, run one sweep.
  - Required: `err_count` = 11, `first_err` = 0, `pass` = 0.
- **Start ignored while busy, then restart:**
  - Stimulus: pulse `start` again while `S` = 5; after completion, pulse `start` from DONE with a correct `O`.
  - Required: the first sweep still completes at 48 cycles with unchanged results. The restart clears status and ends with `pass` = 1.
- **Reset mid-sweep:**
  - Stimulus: assert `rst` while `S` = 7 with `err_count` = 2.
  - Required: same cycle, `S` = 0, `busy` = 0, `err_count` = 0, `done` = 0. No activity until the next `start`.
- **Settle and sample timing:**
  - Stimulus: `SETTLE` = 1, and `O` wrong only at `S` = 13.
  - Required: `done` 32 cycles after `start`, `err_count` = 1, `first_err` = 13. `S` is held exactly 2 cycles per code.

Source files
------------

// File: rtl/minterm_sweep_checker.sv
// minterm_sweep_checker
//   On-board self-test sweep for a 4-input minterm decoder. Drives the select
//   code S through 0..15, holds each code for SETTLE cycles, then samples the
//   decoder output O against EXPECT_MASK[S]. Reports the mismatch count, the
//   lowest failing code and pass/done status.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   start           begin a sweep (honoured in IDLE/DONE only)
//   S               select code driven to the decoder
//   O               decoder output under test (synchronous to clk)
//   busy            sweep in progress
//   done            sweep finished, held until next accepted start or reset
//   pass            registered: done with zero mismatches
//   err_count       number of mismatching codes, 0..16
//   first_err       lowest mismatching code
//   first_err_valid a mismatch has been recorded
module minterm_sweep_checker #(
  parameter logic [15:0] EXPECT_MASK = 16'hA888,
  parameter int unsigned SETTLE      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] S,
  input  logic       O,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_err,
  output logic       first_err_valid
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [3:0] s_nx;
  logic       busy_nx, done_nx, pass_nx;
  logic [4:0] err_nx;
  logic [3:0] first_nx;
  logic       fev_nx;
  logic       mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      S               <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err       <= '0;
      first_err_valid <= 1'b0;
    end else begin
      state           <= state_nx;
      cnt             <= cnt_nx;
      S               <= s_nx;
      busy            <= busy_nx;
      done            <= done_nx;
      pass            <= pass_nx;
      err_count       <= err_nx;
      first_err       <= first_nx;
      first_err_valid <= fev_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    s_nx     = S;
    busy_nx  = busy;
    done_nx  = done;
    pass_nx  = pass;
    err_nx   = err_count;
    first_nx = first_err;
    fev_nx   = first_err_valid;
    mismatch = (O != EXPECT_MASK[S]);

    case (state)
      IDLE, DONE: begin
        if (start) begin
          err_nx   = '0;
          first_nx = '0;
          fev_nx   = 1'b0;
          s_nx     = '0;
          busy_nx  = 1'b1;
          done_nx  = 1'b0;
          pass_nx  = 1'b0;
          cnt_nx   = SETTLE_LD;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        // Leaving on count 1 gives exactly SETTLE cycles in DRIVE.
        cnt_nx = cnt - 8'd1;
        if (cnt == 8'd1) state_nx = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch) begin
          err_nx = err_count + 5'd1;
          if (!first_err_valid) begin
            first_nx = S;
            fev_nx   = 1'b1;
          end
        end
        if (S == 4'd15) begin
          state_nx = DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          // Uses the post-update count so the final code is included.
          pass_nx  = (err_nx == 5'd0);
        end else begin
          s_nx     = S + 4'd1;
          cnt_nx   = SETTLE_LD;
          state_nx = DRIVE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
